// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit (mult, multu, div, divu, mthi, mtlo) owning the HI/LO pair.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational multiplier.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic             MtHi,
    input  logic             MtLo,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rw, qw, b_mag;
    logic               is_div, a_neg, b_neg, b_zero;
    logic               start_go, fix_wr, fast_go;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi, res_lo;

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
        logic signed [WIDTH-1:0] sv;
        sv = $signed(v);
        return neg ? $unsigned(-sv) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate2_if(input logic [2*WIDTH-1:0] v, input logic neg);
        logic signed [2*WIDTH-1:0] sv;
        sv = $signed(v);
        return neg ? $unsigned(-sv) : v;
    endfunction

    assign start_go = (state == IDLE) && Start && !Flush;
    assign fix_wr   = (state == FIX) && !Flush;

`ifdef MULDIV_FAST_MUL_EN
    assign fast_go = !Op[1];
    assign Busy    = (state == RUN) || ((state == FIX) && is_div);
`else
    assign fast_go = 1'b0;
    assign Busy    = (state != IDLE);
`endif

    // One shift-add (multiply) or restoring shift-subtract (divide) step on {rw, qw}
    always_comb begin
        mul_sum   = {1'b0, rw} + {1'b0, (qw[0] ? b_mag : {WIDTH{1'b0}})};
        div_shift = {rw, qw[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag};
    end

    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        prod = negate2_if({{WIDTH{1'b0}}, qw} * {{WIDTH{1'b0}}, b_mag}, a_neg ^ b_neg);
`else
        prod = negate2_if({rw, qw}, a_neg ^ b_neg);
`endif
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div && b_zero) begin
            // qw still holds |dividend| because divide steps are skipped for a zero divisor
            res_hi = negate_if(qw, a_neg);
            res_lo = {WIDTH{1'b1}};
        end else if (is_div) begin
            res_hi = negate_if(rw, a_neg);
            res_lo = negate_if(qw, a_neg ^ b_neg);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_go) state_nxt = fast_go ? FIX : RUN;
            RUN:     if (Flush) state_nxt = IDLE;
                     else if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            cnt    <= '0;
            rw     <= '0;
            qw     <= '0;
            b_mag  <= '0;
            is_div <= 1'b0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            b_zero <= 1'b0;
            HI     <= '0;
            LO     <= '0;
            Done   <= 1'b0;
        end else begin
            state <= state_nxt;
            Done  <= fix_wr;
            if (fix_wr) begin
                HI <= res_hi;
                LO <= res_lo;
            end else if ((state == IDLE) && !start_go) begin
                if (MtHi) HI <= BusA;
                if (MtLo) LO <= BusA;
            end
            if (start_go) begin
                cnt    <= '0;
                rw     <= '0;
                qw     <= negate_if(BusA, !Op[0] && BusA[WIDTH-1]);
                b_mag  <= negate_if(BusB, !Op[0] && BusB[WIDTH-1]);
                is_div <= Op[1];
                a_neg  <= !Op[0] && BusA[WIDTH-1];
                b_neg  <= !Op[0] && BusB[WIDTH-1];
                b_zero <= (BusB == '0);
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                if (!is_div) begin
                    rw <= mul_sum[WIDTH:1];
                    qw <= {mul_sum[0], qw[WIDTH-1:1]};
                end else if (!b_zero) begin
                    if (!div_diff[WIDTH]) begin
                        rw <= div_diff[WIDTH-1:0];
                        qw <= {qw[WIDTH-2:0], 1'b1};
                    end else begin
                        rw <= div_shift[WIDTH-1:0];
                        qw <= {qw[WIDTH-2:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: random and directed ops against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset, Start, MtHi, MtLo, Flush;
    logic [1:0]    Op;
    logic [W-1:0]  BusA, BusB;
    logic          Busy, Done;
    logic [W-1:0]  HI, LO;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .BusA(BusA), .BusB(BusB),
        .MtHi(MtHi), .MtLo(MtLo), .Flush(Flush), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    // Reference: result {HI,LO} straight from the arithmetic definition of each op
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        if (op == 2'b00) begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return sp;
        end
        if (op == 2'b01) return {32'b0, a} * {32'b0, b};
        if (b == 32'b0) return {a, 32'hFFFFFFFF};
        if (op == 2'b10 && a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        if (op == 2'b10) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic int exp_lat(input logic [1:0] op);
        return (FAST && !op[1]) ? 1 : W + 1;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        Start = 1'b1; Op = op; BusA = a; BusB = b;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!Done && lat < 200) begin
            @(posedge Clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat, output logic busy0, output logic busy_end);
        launch(op, a, b);
        busy0 = Busy;
        wait_done(lat);
        res = {HI, LO};
        busy_end = Busy;
    endtask

    task automatic test_reset();
        int lat;
        int dones;
        Reset = 1'b0; Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0; Flush = 1'b0;
        Op = 2'b00; BusA = '0; BusB = '0;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", Done); end
        checks++; if ({HI, LO} !== 64'h0) begin errors++; $display("FAIL reset_hilo got %h exp 0", {HI, LO}); end
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        MtHi = 1'b1; MtLo = 1'b1; BusA = 32'h55;
        @(posedge Clk);
        #1;
        MtHi = 1'b0; MtLo = 1'b0;
        launch(2'b11, 32'd1000, 32'd3);
        repeat (10) @(posedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrun_reset_busy got %b exp 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL midrun_reset_done got %b exp 0", Done); end
        checks++; if ({HI, LO} !== 64'h0) begin errors++; $display("FAIL midrun_reset_hilo got %h exp 0", {HI, LO}); end
        @(negedge Clk);
        Reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            #1;
            if (Done) dones++;
        end
        lat = dones;
        checks++; if (lat !== 0) begin errors++; $display("FAIL reset_no_done got %0d exp 0", lat); end
    endtask

    task automatic test_mult();
        logic [1:0]  ops [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
        logic [31:0] as  [4] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] bs  [4] = '{32'h3, 32'h3, 32'h80000000, 32'hFFFFFFFF};
        logic [63:0] res, e;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic        b0, b1;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            if (i < 4) begin
                op = ops[i]; a = as[i]; b = bs[i];
            end else begin
                op = 2'($urandom_range(0, 1)); a = rnd_word(); b = rnd_word();
            end
            e = model(op, a, b);
            run_op(op, a, b, res, lat, b0, b1);
            checks++; if (res !== e) begin errors++; $display("FAIL mult_result op %0d a %h b %h got %h exp %h", op, a, b, res, e); end
            checks++; if (lat != exp_lat(op)) begin errors++; $display("FAIL mult_latency got %0d exp %0d", lat, exp_lat(op)); end
            checks++; if (b0 !== !FAST) begin errors++; $display("FAIL mult_busy_start got %b exp %b", b0, !FAST); end
            checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL mult_busy_end got %b exp 0", b1); end
        end
    endtask

    task automatic test_div();
        logic [1:0]  ops [7] = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
        logic [31:0] as  [7] = '{32'hFFFFFFF9, 32'd100, 32'd5, 32'h80000000, 32'hFFFFFFF9, 32'd7, 32'h0};
        logic [31:0] bs  [7] = '{32'd2, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE, 32'd0};
        logic [63:0] res, e;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic        b0, b1;
        int          lat;
        for (int i = 0; i < 17; i++) begin
            if (i < 7) begin
                op = ops[i]; a = as[i]; b = bs[i];
            end else begin
                op = 2'($urandom_range(2, 3)); a = rnd_word();
                b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : rnd_word();
            end
            e = model(op, a, b);
            run_op(op, a, b, res, lat, b0, b1);
            checks++; if (res !== e) begin errors++; $display("FAIL div_result op %0d a %h b %h got %h exp %h", op, a, b, res, e); end
            checks++; if (lat != W + 1) begin errors++; $display("FAIL div_latency got %0d exp %0d", lat, W + 1); end
            checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL div_busy_start got %b exp 1", b0); end
            checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL div_busy_end got %b exp 0", b1); end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        launch(2'b11, 32'd100, 32'd7);
        lat = 0;
        while (!Done && lat < 200) begin
            if (lat == 3) begin
                Start = 1'b1; Op = 2'b00; BusA = 32'h1234; BusB = 32'd5; MtHi = 1'b1;
            end
            @(posedge Clk);
            #1;
            Start = 1'b0; MtHi = 1'b0;
            lat++;
        end
        checks++; if (lat != W + 1) begin errors++; $display("FAIL busy_ignore_latency got %0d exp %0d", lat, W + 1); end
        checks++; if ({HI, LO} !== {32'd2, 32'd14}) begin errors++; $display("FAIL busy_ignore_result got %h exp %h", {HI, LO}, {32'd2, 32'd14}); end
        @(posedge Clk);
        #1;
        checks++; if ({Busy, Done} !== 2'b00) begin errors++; $display("FAIL busy_ignore_no_restart got %b exp 00", {Busy, Done}); end
        MtLo = 1'b1; BusA = 32'hABCD;
        @(posedge Clk);
        #1;
        MtLo = 1'b0;
        checks++; if ({HI, LO} !== {32'd2, 32'hABCD}) begin errors++; $display("FAIL mtlo_idle got %h exp %h", {HI, LO}, {32'd2, 32'hABCD}); end
        MtHi = 1'b1; MtLo = 1'b1; BusA = 32'hCAFE;
        @(posedge Clk);
        #1;
        MtHi = 1'b0; MtLo = 1'b0;
        checks++; if ({HI, LO} !== {32'hCAFE, 32'hCAFE}) begin errors++; $display("FAIL mthi_mtlo_both got %h exp %h", {HI, LO}, {32'hCAFE, 32'hCAFE}); end
        @(negedge Clk);
        Start = 1'b1; MtHi = 1'b1; Op = 2'b11; BusA = 32'd9; BusB = 32'd2;
        @(posedge Clk);
        #1;
        Start = 1'b0; MtHi = 1'b0;
        checks++; if (HI !== 32'hCAFE) begin errors++; $display("FAIL start_drops_move got %h exp %h", HI, 32'hCAFE); end
        wait_done(lat);
        checks++; if ({HI, LO} !== {32'd1, 32'd4}) begin errors++; $display("FAIL start_with_move_result got %h exp %h", {HI, LO}, {32'd1, 32'd4}); end
    endtask

    task automatic test_flush();
        logic [31:0] h0, l0;
        int          dones;
        h0 = HI; l0 = LO;
        launch(2'b10, $urandom, 32'($urandom_range(1, 1000)));
        repeat (9) @(posedge Clk);
        #1;
        Flush = 1'b1;
        @(posedge Clk);
        #1;
        Flush = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", Busy); end
        checks++; if ({HI, LO} !== {h0, l0}) begin errors++; $display("FAIL flush_hilo got %h exp %h", {HI, LO}, {h0, l0}); end
        @(negedge Clk);
        Start = 1'b1; Flush = 1'b1; Op = 2'b11; BusA = 32'd50; BusB = 32'd3;
        @(posedge Clk);
        #1;
        Start = 1'b0; Flush = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy got %b exp 0", Busy); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            #1;
            if (Done) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL flush_no_done got %0d exp 0", dones); end
        checks++; if ({HI, LO} !== {h0, l0}) begin errors++; $display("FAIL flush_hilo_later got %h exp %h", {HI, LO}, {h0, l0}); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res, e;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic        b0, b1;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3)); a = rnd_word(); b = rnd_word();
            e = model(op, a, b);
            run_op(op, a, b, res, lat, b0, b1);
            checks++; if (res !== e) begin errors++; $display("FAIL b2b_result op %0d a %h b %h got %h exp %h", op, a, b, res, e); end
            checks++; if (lat != exp_lat(op)) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", lat, exp_lat(op)); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_busy_ignore();
        test_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
